// File: rtl/voice_pkg.sv
// Shared types and widths for the voice record/playback buffer.
// Latency: n/a (types only); backpressure: n/a.
package voice_pkg;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } state_t;
endpackage

// File: rtl/voice_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Latency: read data 1 cycle after re; backpressure: none, caller paces accesses.
module voice_ram
    import voice_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/voice_buf_ctrl.sv
// Record/playback sequencer around voice_ram, driven by audio-top sample strobes.
// Latency: write at strobe edge+1, read data out at edge+3; no backpressure (strobes >=1us apart).
module voice_buf_ctrl
    import voice_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter bit LOOP   = 1'b0
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                key_rec,
    input  logic                key_play,
    input  logic [SAMPLE_W-1:0] wav_in_data,
    input  logic                wav_wren,
    input  logic                wav_rden,
    output logic [SAMPLE_W-1:0] wav_out_data,
    output logic                record_start,
    output logic                voice_write_done,
    output logic                wr_load,
    output logic                rd_load,
    output logic                busy,
    output logic [ADDR_W:0]     rec_len
);

    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_t state, state_nxt;

    logic                wren_prev, rden_prev;
    logic                wr_evt, rd_evt;
    logic [ADDR_W:0]     wr_cnt, rd_cnt;
    logic                play_done;
    logic                s1_vld, s1_last, s2_vld, s2_last, s3_last;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [SAMPLE_W-1:0] ram_rdata, out_q;

    logic start_rec, start_play, end_rec, ram_we, rd_issue, rd_is_last;

    assign wr_evt = wav_wren & ~wren_prev;
    assign rd_evt = wav_rden & ~rden_prev;

    always_ff @(posedge clk50M) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_rec  = 1'b0;
        start_play = 1'b0;
        end_rec    = 1'b0;
        ram_we     = 1'b0;
        rd_issue   = 1'b0;
        rd_is_last = 1'b0;
        case (state)
            IDLE: begin
                if (key_rec) begin
                    start_rec = 1'b1;
                    state_nxt = REC;
                end else if (key_play && rec_len != '0) begin
                    start_play = 1'b1;
                    state_nxt  = PLAY;
                end
            end
            REC: begin
                ram_we = wr_evt;
                // A write into the top address fills the buffer and closes the take.
                if (key_rec || (wr_evt && wr_cnt == LAST_ADDR)) begin
                    end_rec   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PLAY: begin
                if (key_rec) begin
                    start_rec = 1'b1;
                    state_nxt = REC;
                end else begin
                    rd_issue   = rd_evt && !play_done;
                    rd_is_last = (rd_cnt + ONE) == rec_len;
                    // Leave only once the final sample has reached wav_out_data.
                    if (s3_last && !LOOP)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            wren_prev        <= 1'b0;
            rden_prev        <= 1'b0;
            wr_load          <= 1'b0;
            rd_load          <= 1'b0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            rec_len          <= '0;
            voice_write_done <= 1'b0;
            play_done        <= 1'b0;
            s1_vld           <= 1'b0;
            s1_last          <= 1'b0;
            s2_vld           <= 1'b0;
            s2_last          <= 1'b0;
            s3_last          <= 1'b0;
            rd_addr_q        <= '0;
            out_q            <= '0;
        end else begin
            wren_prev <= wav_wren;
            rden_prev <= wav_rden;
            wr_load   <= start_rec;
            rd_load   <= start_play | (rd_issue & rd_is_last & LOOP);

            if (start_rec) begin
                wr_cnt           <= '0;
                voice_write_done <= 1'b0;
            end else if (ram_we) begin
                wr_cnt <= wr_cnt + ONE;
            end

            if (end_rec) begin
                rec_len          <= wr_cnt + (ram_we ? ONE : '0);
                voice_write_done <= 1'b1;
            end

            if (start_play) begin
                rd_cnt    <= '0;
                play_done <= 1'b0;
            end else if (rd_issue) begin
                if (rd_is_last) begin
                    rd_cnt    <= '0;
                    play_done <= ~LOOP;
                end else begin
                    rd_cnt <= rd_cnt + ONE;
                end
            end

            // Three-stage read pipe: address issue, RAM output, output register.
            s1_vld    <= rd_issue;
            s1_last   <= rd_issue & rd_is_last;
            rd_addr_q <= rd_cnt[ADDR_W-1:0];
            s2_vld    <= s1_vld;
            s2_last   <= s1_last;
            s3_last   <= s2_vld & s2_last;
            if (s2_vld)
                out_q <= ram_rdata;

            if (start_rec || start_play) begin
                s1_vld  <= 1'b0;
                s1_last <= 1'b0;
                s2_vld  <= 1'b0;
                s2_last <= 1'b0;
                s3_last <= 1'b0;
                out_q   <= '0;
            end
        end
    end

    voice_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk50M),
        .we    (ram_we),
        .waddr (wr_cnt[ADDR_W-1:0]),
        .wdata (wav_in_data),
        .re    (s1_vld),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    assign busy         = (state != IDLE);
    assign record_start = (state == REC);
    assign wav_out_data = (state == PLAY) ? out_q : '0;

endmodule

// File: tb/tb_voice_buf_ctrl.sv
// Directed bench for voice_buf_ctrl: default instance plus ADDR_W=4 single-pass and looping instances.
// All three share stimulus; each scenario checks the instance it targets.
module tb_voice_buf_ctrl;

    logic        clk50M = 1'b0;
    logic        rst;
    logic        key_rec, key_play;
    logic [15:0] wav_in_data;
    logic        wav_wren, wav_rden;

    logic [15:0] dout [3];
    logic [2:0]  rs, wd, wl, rl, bz;
    logic [14:0] len0;
    logic [4:0]  len1, len2;

    int checks = 0;
    int errors = 0;

    always #10 clk50M = ~clk50M;

    voice_buf_ctrl #(.ADDR_W(14), .LOOP(1'b0)) u_dut0 (
        .clk50M(clk50M), .rst(rst), .key_rec(key_rec), .key_play(key_play),
        .wav_in_data(wav_in_data), .wav_wren(wav_wren), .wav_rden(wav_rden),
        .wav_out_data(dout[0]), .record_start(rs[0]), .voice_write_done(wd[0]),
        .wr_load(wl[0]), .rd_load(rl[0]), .busy(bz[0]), .rec_len(len0));

    voice_buf_ctrl #(.ADDR_W(4), .LOOP(1'b0)) u_dut1 (
        .clk50M(clk50M), .rst(rst), .key_rec(key_rec), .key_play(key_play),
        .wav_in_data(wav_in_data), .wav_wren(wav_wren), .wav_rden(wav_rden),
        .wav_out_data(dout[1]), .record_start(rs[1]), .voice_write_done(wd[1]),
        .wr_load(wl[1]), .rd_load(rl[1]), .busy(bz[1]), .rec_len(len1));

    voice_buf_ctrl #(.ADDR_W(4), .LOOP(1'b1)) u_dut2 (
        .clk50M(clk50M), .rst(rst), .key_rec(key_rec), .key_play(key_play),
        .wav_in_data(wav_in_data), .wav_wren(wav_wren), .wav_rden(wav_rden),
        .wav_out_data(dout[2]), .record_start(rs[2]), .voice_write_done(wd[2]),
        .wr_load(wl[2]), .rd_load(rl[2]), .busy(bz[2]), .rec_len(len2));

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk50M);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic press_rec();
        key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
    endtask

    task automatic press_play();
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
    endtask

    task automatic wr_edge(input logic [15:0] d);
        wav_in_data = d;
        wav_wren    = 1'b1;
        tick();
        wav_wren    = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; key_rec = 0; key_play = 0; wav_wren = 0; wav_rden = 0; wav_in_data = 0;
        tick(2);
        checks++;
        if ({rs[0], wd[0], wl[0], rl[0], bz[0]} !== 5'b0 || dout[0] !== 16'h0 || len0 !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got ctl=%b out=%h len=%0d, want ctl=00000 out=0000 len=0",
                     {rs[0], wd[0], wl[0], rl[0], bz[0]}, dout[0], len0);
        end
        rst = 1'b0;
        press_rec();
        for (int i = 1; i <= 5; i++) wr_edge(16'(i));
        checks++;
        if (bz[0] !== 1'b1) begin errors++; $display("FAIL rec_busy_before_reset: got %b want 1", bz[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rs[0], wd[0], wl[0], rl[0], bz[0]} !== 5'b0 || dout[0] !== 16'h0 || len0 !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_rec: got ctl=%b out=%h len=%0d, want ctl=00000 out=0000 len=0",
                     {rs[0], wd[0], wl[0], rl[0], bz[0]}, dout[0], len0);
        end
        press_play();
        checks++;
        if (bz[0] !== 1'b0 || rl[0] !== 1'b0) begin
            errors++;
            $display("FAIL play_after_reset: got busy=%b rd_load=%b want 0 0", bz[0], rl[0]);
        end
    endtask

    task automatic test_record();
        do_reset();
        press_rec();
        checks++;
        if (wl[0] !== 1'b1 || rs[0] !== 1'b1 || bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL rec_entry: got wr_load=%b record_start=%b busy=%b want 1 1 1", wl[0], rs[0], bz[0]);
        end
        tick();
        checks++;
        if (wl[0] !== 1'b0) begin errors++; $display("FAIL wr_load_single: got %b want 0", wl[0]); end
        for (int i = 1; i <= 8; i++) wr_edge(16'(i));
        checks++;
        if (rs[0] !== 1'b1 || wd[0] !== 1'b0) begin
            errors++;
            $display("FAIL rec_capture: got record_start=%b done=%b want 1 0", rs[0], wd[0]);
        end
        press_rec();
        checks++;
        if (rs[0] !== 1'b0 || wd[0] !== 1'b1 || len0 !== 15'd8 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL rec_end: got record_start=%b done=%b len=%0d busy=%b want 0 1 8 0",
                     rs[0], wd[0], len0, bz[0]);
        end
    endtask

    task automatic test_playback();
        press_play();
        checks++;
        if (rl[0] !== 1'b1 || bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL play_entry: got rd_load=%b busy=%b want 1 1", rl[0], bz[0]);
        end
        tick();
        checks++;
        if (rl[0] !== 1'b0) begin errors++; $display("FAIL rd_load_single: got %b want 0", rl[0]); end
        for (int i = 1; i <= 8; i++) begin
            wav_rden = 1'b1;
            tick();
            wav_rden = 1'b0;
            tick(2);
            checks++;
            if (dout[0] !== 16'(i) || bz[0] !== 1'b1) begin
                errors++;
                $display("FAIL play_sample%0d: got out=%h busy=%b want %h 1", i, dout[0], bz[0], 16'(i));
            end
        end
        tick();
        checks++;
        if (bz[0] !== 1'b0 || dout[0] !== 16'h0) begin
            errors++;
            $display("FAIL play_done: got busy=%b out=%h want 0 0000", bz[0], dout[0]);
        end
    endtask

    task automatic test_full();
        do_reset();
        press_rec();
        for (int i = 1; i <= 20; i++) begin
            wr_edge(16'h100 + 16'(i));
            if (i == 16) begin
                checks++;
                if (bz[1] !== 1'b0 || len1 !== 5'd16 || wd[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL full_stop: got busy=%b len=%0d done=%b want 0 16 1", bz[1], len1, wd[1]);
                end
            end
        end
        checks++;
        if (len1 !== 5'd16 || bz[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_after20: got len=%0d busy=%b want 16 0", len1, bz[1]);
        end
        press_play();
        for (int i = 0; i < 16; i++) begin
            wav_rden = 1'b1;
            tick();
            wav_rden = 1'b0;
            tick(2);
            checks++;
            if (dout[1] !== 16'h101 + 16'(i)) begin
                errors++;
                $display("FAIL full_read%0d: got %h want %h", i, dout[1], 16'h101 + 16'(i));
            end
        end
        tick();
        checks++;
        if (bz[1] !== 1'b0) begin errors++; $display("FAIL full_play_end: got busy=%b want 0", bz[1]); end
    endtask

    task automatic test_loop();
        do_reset();
        press_rec();
        for (int i = 1; i <= 3; i++) wr_edge(16'(i));
        press_rec();
        checks++;
        if (len2 !== 5'd3) begin errors++; $display("FAIL loop_len: got %0d want 3", len2); end
        press_play();
        checks++;
        if (rl[2] !== 1'b1) begin errors++; $display("FAIL loop_start_load: got %b want 1", rl[2]); end
        tick();
        for (int i = 0; i < 7; i++) begin
            wav_rden = 1'b1;
            tick();
            wav_rden = 1'b0;
            checks++;
            if (rl[2] !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL loop_rd_load%0d: got %b want %b", i, rl[2], (i % 3 == 2));
            end
            tick(2);
            checks++;
            if (dout[2] !== 16'(i % 3 + 1)) begin
                errors++;
                $display("FAIL loop_read%0d: got %h want %h", i, dout[2], 16'(i % 3 + 1));
            end
        end
        tick(2);
        checks++;
        if (bz[2] !== 1'b1) begin errors++; $display("FAIL loop_still_busy: got %b want 1", bz[2]); end
    endtask

    task automatic test_key_priority();
        do_reset();
        press_rec();
        wr_edge(16'h00A1);
        wr_edge(16'h00A2);
        press_rec();
        key_rec  = 1'b1;
        key_play = 1'b1;
        tick();
        key_rec  = 1'b0;
        key_play = 1'b0;
        checks++;
        if (rs[0] !== 1'b1 || wl[0] !== 1'b1 || rl[0] !== 1'b0 || wd[0] !== 1'b0) begin
            errors++;
            $display("FAIL both_keys: got rs=%b wl=%b rl=%b done=%b want 1 1 0 0", rs[0], wl[0], rl[0], wd[0]);
        end
        wr_edge(16'h00B1);
        press_play();
        checks++;
        if (rs[0] !== 1'b1 || rl[0] !== 1'b0) begin
            errors++;
            $display("FAIL play_in_rec: got rs=%b rl=%b want 1 0", rs[0], rl[0]);
        end
        wr_edge(16'h00B2);
        wr_edge(16'h00B3);
        press_rec();
        checks++;
        if (len0 !== 15'd3 || wd[0] !== 1'b1) begin
            errors++;
            $display("FAIL rec2_end: got len=%0d done=%b want 3 1", len0, wd[0]);
        end
        press_play();
        wav_rden = 1'b1;
        tick();
        wav_rden = 1'b0;
        tick(2);
        checks++;
        if (dout[0] !== 16'h00B1) begin errors++; $display("FAIL rec2_read0: got %h want 00b1", dout[0]); end
        press_rec();
        checks++;
        if (rs[0] !== 1'b1 || wd[0] !== 1'b0 || wl[0] !== 1'b1 || dout[0] !== 16'h0) begin
            errors++;
            $display("FAIL abort_play: got rs=%b done=%b wl=%b out=%h want 1 0 1 0000",
                     rs[0], wd[0], wl[0], dout[0]);
        end
    endtask

    initial begin
        test_reset();
        test_record();
        test_playback();
        test_full();
        test_loop();
        test_key_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
